// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-setting controller for the HH:MM:SS clock (mode/inc buttons, load pulse, blink mask)
module clock_set_ctrl #(
    parameter int HOLD_CYC    = 25000000,
    parameter int REPEAT_CYC  = 5000000,
    parameter int BLINK_CYC   = 12500000,
    parameter int TIMEOUT_CYC = 500000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_mode_n,
    input  logic       i_btn_inc_n,
    input  logic [4:0] i_hh,
    input  logic [5:0] i_mm,
    input  logic [5:0] i_ss,
    output logic       o_run_en,
    output logic       o_load,
    output logic [4:0] o_load_hh,
    output logic [5:0] o_load_mm,
    output logic [5:0] o_load_ss,
    output logic [4:0] o_disp_hh,
    output logic [5:0] o_disp_mm,
    output logic [5:0] o_disp_ss,
    output logic [2:0] o_blank
);

    localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
    localparam int REP_W   = $clog2(REPEAT_CYC + 1);
    localparam int BLINK_W = $clog2(BLINK_CYC + 1);
    localparam int IDLE_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_SET_HH = 2'd1;
    localparam logic [1:0] ST_SET_MM = 2'd2;
    localparam logic [1:0] ST_SET_SS = 2'd3;

    logic               mode_s1, mode_s2, mode_d;
    logic               inc_s1, inc_s2, inc_d;
    logic [1:0]         state_q, state_d;
    logic [4:0]         edit_hh;
    logic [5:0]         edit_mm, edit_ss;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [REP_W-1:0]   rep_cnt;
    logic               rep_active;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               run_en_q, load_q;
    logic [2:0]         blank_q, blank_d;

    logic mode_press, inc_press, in_set;
    logic hold_step, rep_step, inc_step, timeout, state_chg;

    // Compare-then-wrap so out-of-range captured values also fall back to zero.
    function automatic logic [4:0] next_hh(input logic [4:0] v);
        return (v >= 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] next_ms(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    // Two-flop synchronisers plus one delay flop for falling-edge press detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_s1 <= 1'b1;
            mode_s2 <= 1'b1;
            mode_d  <= 1'b1;
            inc_s1  <= 1'b1;
            inc_s2  <= 1'b1;
            inc_d   <= 1'b1;
        end else begin
            mode_s1 <= i_btn_mode_n;
            mode_s2 <= mode_s1;
            mode_d  <= mode_s2;
            inc_s1  <= i_btn_inc_n;
            inc_s2  <= inc_s1;
            inc_d   <= inc_s2;
        end
    end

    assign mode_press = mode_d & ~mode_s2;
    assign inc_press  = inc_d & ~inc_s2;
    assign in_set     = (state_q != ST_RUN);

    // First auto-repeat step once the hold count reaches HOLD_CYC, then every REPEAT_CYC.
    assign hold_step = in_set && !inc_s2 && !rep_active && (hold_cnt != '0)
                       && (hold_cnt == HOLD_W'(HOLD_CYC));
    assign rep_step  = in_set && !inc_s2 && rep_active && (rep_cnt == REP_W'(REPEAT_CYC));
    // A simultaneous mode press wins and swallows the increment.
    assign inc_step  = in_set && !mode_press && (inc_press || hold_step || rep_step);
    assign timeout   = in_set && !mode_press && !inc_step
                       && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    // Next-state: mode advances through the set fields; timeout abandons the edit.
    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            case (state_q)
                ST_RUN:    state_d = ST_SET_HH;
                ST_SET_HH: state_d = ST_SET_MM;
                ST_SET_MM: state_d = ST_SET_SS;
                default:   state_d = ST_RUN;
            endcase
        end else if (timeout) begin
            state_d = ST_RUN;
        end
    end

    assign state_chg = (state_d != state_q);

    // Blink restarts visible on entering a field and on every adjustment.
    always_comb begin
        blink_cnt_d = blink_cnt + BLINK_W'(1);
        phase_d     = phase_q;
        if (state_chg || inc_step || !in_set) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_CYC - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // Only the field being edited may blank.
    always_comb begin
        case (state_d)
            ST_SET_HH: blank_d = {phase_d, 2'b00};
            ST_SET_MM: blank_d = {1'b0, phase_d, 1'b0};
            ST_SET_SS: blank_d = {2'b00, phase_d};
            default:   blank_d = 3'b000;
        endcase
    end

    // State, registered outputs and blink phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_RUN;
            run_en_q  <= 1'b1;
            load_q    <= 1'b0;
            blank_q   <= 3'b000;
            blink_cnt <= '0;
            phase_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_en_q  <= (state_d == ST_RUN);
            load_q    <= (state_q == ST_SET_SS) && mode_press;
            blank_q   <= blank_d;
            blink_cnt <= blink_cnt_d;
            phase_q   <= phase_d;
        end
    end

    // Edit registers: capture on entering set mode, step the active field.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            edit_hh <= '0;
            edit_mm <= '0;
            edit_ss <= '0;
        end else if ((state_q == ST_RUN) && mode_press) begin
            edit_hh <= i_hh;
            edit_mm <= i_mm;
            edit_ss <= i_ss;
        end else if (inc_step) begin
            case (state_q)
                ST_SET_HH: edit_hh <= next_hh(edit_hh);
                ST_SET_MM: edit_mm <= next_ms(edit_mm);
                ST_SET_SS: edit_ss <= next_ms(edit_ss);
                default:   edit_hh <= edit_hh;
            endcase
        end
    end

    // Hold/repeat counters run only while a press made in a set state stays held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            rep_active <= 1'b0;
        end else if (state_chg || inc_s2 || !in_set) begin
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            rep_active <= 1'b0;
        end else if (inc_press) begin
            hold_cnt   <= HOLD_W'(1);
            rep_cnt    <= '0;
            rep_active <= 1'b0;
        end else if (hold_cnt != '0) begin
            if (hold_step) begin
                rep_active <= 1'b1;
                rep_cnt    <= REP_W'(1);
            end else if (rep_active) begin
                rep_cnt <= rep_step ? REP_W'(1) : rep_cnt + REP_W'(1);
            end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    // Idle counter: any activity restarts the abandon-edit window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_cnt <= '0;
        end else if (!in_set || mode_press || inc_step || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign o_run_en  = run_en_q;
    assign o_load    = load_q;
    assign o_blank   = blank_q;
    assign o_load_hh = edit_hh;
    assign o_load_mm = edit_mm;
    assign o_load_ss = edit_ss;
    assign o_disp_hh = (state_q == ST_RUN) ? i_hh : edit_hh;
    assign o_disp_mm = (state_q == ST_RUN) ? i_mm : edit_mm;
    assign o_disp_ss = (state_q == ST_RUN) ? i_ss : edit_ss;

endmodule
